mc_mb_scheduler: RTL and testbench
==================================

Name: mc_mb_scheduler

Overview:
Sequences one macroblock's motion-compensation work through the shared MC datapath. It issues one 4x4 block request per handshake: 16 luma blocks, then optionally 8 chroma blocks. It tracks outstanding completions from the datapath and pulses mb_done when every issued block has returned. It sits between the MB-level encoder control and the MC datapath's src/dst handshake.

Parameters:
MB_ADDR_W, 13, width of macroblock address.
MAX_OUT, 4, maximum blocks in flight in the MC datapath (1..8).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
mb_start  input  1  request to start a macroblock; accepted only in IDLE.
mb_addr  input  MB_ADDR_W  macroblock address; latched on an accepted mb_start.
abort  input  1  synchronous abort of the current macroblock.
busy  output  1  high in any state other than IDLE.
mb_done  output  1  one-cycle pulse when all blocks have completed.
blk_valid  output  1  block request valid to the MC datapath.
blk_ready  input  1  MC datapath accepts the request.
blk_comp  output  2  component: 0 = Y, 1 = Cb, 2 = Cr.
blk_idx  output  4  4x4 block index within the component.
blk_mb_addr  output  MB_ADDR_W  latched macroblock address.
res_valid  input  1  MC datapath reports one block completed.
res_ready  output  1  scheduler accepts the completion.

Behaviour:
- Reset values: busy=0, mb_done=0, blk_valid=0, res_ready=0, blk_comp=0, blk_idx=0, blk_mb_addr=0. State=IDLE; issue_cnt, done_cnt and outstanding all 0.
- TOTAL = 24 when MC_CHROMA_EN is defined, else 16.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on mb_start=1, latch mb_addr into blk_mb_addr, clear all counters, go to ISSUE. blk_valid rises in the next cycle, giving 1-cycle start latency.
- ISSUE: blk_valid = (outstanding < MAX_OUT).
  - A handshake (blk_valid & blk_ready) increments issue_cnt and outstanding.
  - On the handshake of block TOTAL-1, go to DRAIN.
- Mapping from issue_cnt:
  - 0-15: blk_comp=0, blk_idx=issue_cnt.
  - 16-19: blk_comp=1, blk_idx=issue_cnt-16.
  - 20-23: blk_comp=2, blk_idx=issue_cnt-20.
- Payload is driven from registered counters and held stable while blk_valid=1 and blk_ready=0.
- Once asserted, blk_valid stays high until the handshake, because outstanding can only decrease without an issue.
- res_ready = busy & (outstanding != 0) & !abort.
  - A completion (res_valid & res_ready) increments done_cnt and decrements outstanding.
  - An issue and a completion in the same cycle leave outstanding unchanged.
- DRAIN: blk_valid=0. When done_cnt reaches TOTAL, counting the completion arriving in this cycle, go to DONE.
- DONE: mb_done=1 for exactly one cycle, busy=1, then IDLE. A new mb_start is accepted in the first IDLE cycle after DONE, so macroblocks are back-to-back with a 2-cycle bubble.
- mb_start outside IDLE is ignored; no queuing.
- res_valid with outstanding=0 is not accepted (res_ready=0) and not counted.
- abort=1 in a non-IDLE state:
  - Next state is IDLE with all counters cleared; no mb_done.
  - Any blk/res handshake in the same cycle is discarded. blk_valid and res_ready are forced low in that cycle.
  - abort in IDLE has no effect.
- Reset mid-operation returns to the reset values immediately.
- Counter widths: issue_cnt and done_cnt 5 bits; outstanding $clog2(MAX_OUT+1) bits. No wrap is possible within a macroblock.

Optional Feature:
MC_CHROMA_EN:
- Defined: TOTAL=24; Cb blocks 0-3 then Cr blocks 0-3 follow the luma blocks.
- Undefined: TOTAL=16; luma only; blk_comp is always 0 and the chroma mapping logic is absent.

Test Plan:
1. Smoke run: mb_start with mb_addr=0x0A5, blk_ready=1, res_valid returned 2 cycles after each issue.
   Required: 24 issues in order Y0..Y15, Cb0..Cb3, Cr0..Cr3; blk_mb_addr=0x0A5 throughout; a single mb_done pulse after the 24th completion. With the macro undefined: 16 issues.
2. Backpressure: MAX_OUT=4, res_valid held low.
   Required: exactly 4 issues, then blk_valid=0. A single completion pulse produces exactly one more issue, with payload Y4.
3. Stall stability: blk_ready=0 for 5 cycles while requesting Y7.
   Required: blk_valid, blk_comp and blk_idx stay at 1, 0 and 7 every cycle; exactly one handshake counted.
4. Simultaneous events: issue and completion in the same cycle with outstanding=3.
   Required: outstanding stays 3. Also, res_valid in IDLE → res_ready=0 and the next macroblock still needs the full TOTAL completions.
5. Abort: abort asserted after 10 issues and 6 completions, with blk_ready=1 in the same cycle.
   Required: IDLE next cycle, busy=0, no mb_done. A following mb_start restarts at Y0.
6. Reset/start guards: async reset asserted mid-DRAIN → all outputs 0 immediately. mb_start pulsed in ISSUE → ignored; blk_mb_addr is unchanged.

Source files
------------

// File: rtl/mc_mb_scheduler_if.sv
// Block-request / completion handshake between the MB scheduler and the MC datapath.
interface mc_mb_scheduler_if #(
  parameter int unsigned MB_ADDR_W = 13
);
  logic                 blk_valid;
  logic                 blk_ready;
  logic [1:0]           blk_comp;
  logic [3:0]           blk_idx;
  logic [MB_ADDR_W-1:0] blk_mb_addr;
  logic                 res_valid;
  logic                 res_ready;

  modport master (
    output blk_valid, blk_comp, blk_idx, blk_mb_addr, res_ready,
    input  blk_ready, res_valid
  );

  modport slave (
    input  blk_valid, blk_comp, blk_idx, blk_mb_addr, res_ready,
    output blk_ready, res_valid
  );
endinterface

// File: rtl/mc_mb_scheduler.sv
// Issues one macroblock's 4x4 MC block requests and tracks their completions.
// Optional chroma issue (Cb0..3, Cr0..3 after luma) is enabled by defining MC_CHROMA_EN.
module mc_mb_scheduler #(
  parameter int unsigned MB_ADDR_W = 13,
  parameter int unsigned MAX_OUT   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mb_start,
  input  logic [MB_ADDR_W-1:0] mb_addr,
  input  logic                 abort,
  output logic                 busy,
  output logic                 mb_done,
  mc_mb_scheduler_if.master    bus
);

`ifdef MC_CHROMA_EN
  localparam int unsigned TOTAL = 24;
`else
  localparam int unsigned TOTAL = 16;
`endif
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [4:0]           r_issue_cnt;
  logic [4:0]           r_done_cnt;
  logic [OUT_W-1:0]     r_outstanding;
  logic [MB_ADDR_W-1:0] r_mb_addr;

  logic       w_blk_valid;
  logic       w_res_ready;
  logic       w_issue;
  logic       w_comp;
  logic [4:0] w_done_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    busy         = (r_state != S_IDLE);
    mb_done      = 1'b0;
    // abort masks both handshakes so nothing is counted in the aborting cycle
    w_blk_valid  = (r_state == S_ISSUE) && (r_outstanding < OUT_W'(MAX_OUT)) && !abort;
    w_res_ready  = busy && (r_outstanding != '0) && !abort;
    w_issue      = w_blk_valid && bus.blk_ready;
    w_comp       = w_res_ready && bus.res_valid;
    w_done_nxt   = r_done_cnt + 5'(w_comp);
    unique case (r_state)
      S_IDLE: begin
        if (mb_start) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (abort)                                           w_next_state = S_IDLE;
        else if (w_issue && (r_issue_cnt == 5'(TOTAL - 1)))  w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                          w_next_state = S_IDLE;
        else if (w_done_nxt == 5'(TOTAL))   w_next_state = S_DONE;
      end
      S_DONE: begin
        mb_done      = !abort;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_issue_cnt   <= '0;
      r_done_cnt    <= '0;
      r_outstanding <= '0;
      r_mb_addr     <= '0;
    end else if (r_state == S_IDLE) begin
      if (mb_start) begin
        r_mb_addr     <= mb_addr;
        r_issue_cnt   <= '0;
        r_done_cnt    <= '0;
        r_outstanding <= '0;
      end
    end else if (abort || (r_state == S_DONE)) begin
      // counters return to zero whenever IDLE is re-entered so payload reads Y0 there
      r_issue_cnt   <= '0;
      r_done_cnt    <= '0;
      r_outstanding <= '0;
    end else begin
      r_issue_cnt   <= r_issue_cnt + 5'(w_issue);
      r_done_cnt    <= w_done_nxt;
      r_outstanding <= r_outstanding + OUT_W'(w_issue) - OUT_W'(w_comp);
    end
  end

  always_comb begin
    bus.blk_comp = '0;
    bus.blk_idx  = r_issue_cnt[3:0];
`ifdef MC_CHROMA_EN
    if (r_issue_cnt >= 5'd20) begin
      bus.blk_comp = 2'd2;
      bus.blk_idx  = {2'b00, r_issue_cnt[1:0]};
    end else if (r_issue_cnt >= 5'd16) begin
      bus.blk_comp = 2'd1;
      bus.blk_idx  = {2'b00, r_issue_cnt[1:0]};
    end
`endif
  end

  assign bus.blk_valid   = w_blk_valid;
  assign bus.res_ready   = w_res_ready;
  assign bus.blk_mb_addr = r_mb_addr;

endmodule

// File: tb/tb_mc_mb_scheduler.sv
// Directed self-checking bench for mc_mb_scheduler (luma-only or with MC_CHROMA_EN).
module tb_mc_mb_scheduler;

`ifdef MC_CHROMA_EN
  localparam int TOTAL = 24;
`else
  localparam int TOTAL = 16;
`endif

  logic        clk;
  logic        reset;
  logic        mb_start;
  logic [12:0] mb_addr;
  logic        abort;
  logic        busy;
  logic        mb_done;
  int          n_checks;
  int          n_fail;

  mc_mb_scheduler_if #(.MB_ADDR_W(13)) bus ();

  mc_mb_scheduler #(.MB_ADDR_W(13), .MAX_OUT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .mb_start (mb_start),
    .mb_addr  (mb_addr),
    .abort    (abort),
    .busy     (busy),
    .mb_done  (mb_done),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mb_start = 1'b0; mb_addr = '0; abort = 1'b0;
    bus.blk_ready = 1'b0; bus.res_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_mb(input logic [12:0] addr);
    mb_addr = addr; mb_start = 1'b1;
    @(negedge clk);
    mb_start = 1'b0; mb_addr = '0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({busy, mb_done, bus.blk_valid, bus.res_ready, bus.blk_comp, bus.blk_idx, bus.blk_mb_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%0b done=%0b bv=%0b rr=%0b comp=%0d idx=%0d addr=%0h, required all 0",
               busy, mb_done, bus.blk_valid, bus.res_ready, bus.blk_comp, bus.blk_idx, bus.blk_mb_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %0b required 0", busy); end
  endtask

  task automatic test_smoke();
    int due[$];
    int issued, comps, pulses;
    logic [1:0] ec;
    logic [3:0] ei;
    issued = 0; comps = 0; pulses = 0;
    do_reset();
    start_mb(13'h0A5);
    for (int cyc = 0; cyc < 200; cyc++) begin
      bus.blk_ready = 1'b1;
      bus.res_valid = (due.size() > 0) && (due[0] <= cyc);
      #1;
      if (bus.blk_valid && bus.blk_ready) begin
        if (issued < 16)      begin ec = 2'd0; ei = 4'(issued); end
        else if (issued < 20) begin ec = 2'd1; ei = 4'(issued - 16); end
        else                  begin ec = 2'd2; ei = 4'(issued - 20); end
        n_checks++;
        if (bus.blk_comp !== ec) begin n_fail++; $display("FAIL smoke_comp[%0d]: got %0d required %0d", issued, bus.blk_comp, ec); end
        n_checks++;
        if (bus.blk_idx !== ei) begin n_fail++; $display("FAIL smoke_idx[%0d]: got %0d required %0d", issued, bus.blk_idx, ei); end
        n_checks++;
        if (bus.blk_mb_addr !== 13'h0A5) begin n_fail++; $display("FAIL smoke_addr[%0d]: got %0h required 0a5", issued, bus.blk_mb_addr); end
        issued++;
        due.push_back(cyc + 2);
      end
      if (bus.res_valid && bus.res_ready) begin
        void'(due.pop_front());
        comps++;
      end
      if (mb_done) begin
        pulses++;
        n_checks++;
        if (comps !== TOTAL) begin n_fail++; $display("FAIL smoke_done_early: completions %0d required %0d", comps, TOTAL); end
      end
      @(negedge clk);
      if (pulses > 0) break;
    end
    bus.res_valid = 1'b0;
    #1;
    n_checks++;
    if (issued !== TOTAL) begin n_fail++; $display("FAIL smoke_issue_count: got %0d required %0d", issued, TOTAL); end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL smoke_done_pulses: got %0d required 1", pulses); end
    n_checks++;
    if ({busy, mb_done} !== 2'b00) begin n_fail++; $display("FAIL smoke_after_done: busy/done %b required 00", {busy, mb_done}); end
  endtask

  task automatic test_backpressure();
    int hs;
    logic [3:0] last_idx;
    logic [1:0] last_comp;
    hs = 0; last_idx = 4'hF; last_comp = 2'd3;
    do_reset();
    start_mb(13'h001);
    bus.blk_ready = 1'b1; bus.res_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.blk_valid && bus.blk_ready) hs++;
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (hs !== 4) begin n_fail++; $display("FAIL bp_issue_count: got %0d required 4", hs); end
    n_checks++;
    if (bus.blk_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_low: got %0b required 0", bus.blk_valid); end
    bus.res_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.res_ready !== 1'b1) begin n_fail++; $display("FAIL bp_res_ready: got %0b required 1", bus.res_ready); end
    @(negedge clk);
    bus.res_valid = 1'b0;
    hs = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.blk_valid && bus.blk_ready) begin hs++; last_idx = bus.blk_idx; last_comp = bus.blk_comp; end
      @(negedge clk);
    end
    n_checks++;
    if (hs !== 1) begin n_fail++; $display("FAIL bp_one_more: got %0d issues required 1", hs); end
    n_checks++;
    if ({last_comp, last_idx} !== {2'd0, 4'd4}) begin
      n_fail++; $display("FAIL bp_payload: got comp %0d idx %0d required comp 0 idx 4", last_comp, last_idx);
    end
  endtask

  task automatic test_stall();
    int hs, hs_stall;
    hs = 0; hs_stall = 0;
    do_reset();
    start_mb(13'h002);
    bus.blk_ready = 1'b1; bus.res_valid = 1'b1;
    for (int c = 0; c < 40 && hs < 7; c++) begin
      #1;
      if (bus.blk_valid && bus.blk_ready) hs++;
      @(negedge clk);
    end
    bus.blk_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if ({bus.blk_valid, bus.blk_comp, bus.blk_idx} !== {1'b1, 2'd0, 4'd7}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: valid %0b comp %0d idx %0d required 1/0/7",
                           c, bus.blk_valid, bus.blk_comp, bus.blk_idx);
      end
      if (bus.blk_valid && bus.blk_ready) hs_stall++;
      @(negedge clk);
    end
    bus.blk_ready = 1'b1;
    #1;
    if (bus.blk_valid && bus.blk_ready) hs_stall++;
    @(negedge clk);
    bus.blk_ready = 1'b0;
    #1;
    n_checks++;
    if (hs_stall !== 1) begin n_fail++; $display("FAIL stall_handshakes: got %0d required 1", hs_stall); end
    n_checks++;
    if (bus.blk_idx !== 4'd8) begin n_fail++; $display("FAIL stall_next_idx: got %0d required 8", bus.blk_idx); end
  endtask

  task automatic test_simultaneous();
    int hs, comps, pulses;
    logic rr_seen;
    hs = 0; comps = 0; pulses = 0; rr_seen = 1'b0;
    do_reset();
    start_mb(13'h003);
    bus.blk_ready = 1'b1; bus.res_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.blk_valid && bus.blk_ready) hs++;
      @(negedge clk);
    end
    n_checks++;
    if (hs !== 3) begin n_fail++; $display("FAIL sim_prefill: got %0d issues required 3", hs); end
    bus.res_valid = 1'b1;
    #1;
    n_checks++;
    if ({bus.blk_valid, bus.res_ready} !== 2'b11) begin
      n_fail++; $display("FAIL sim_both_hs: valid/res_ready %b required 11", {bus.blk_valid, bus.res_ready});
    end
    @(negedge clk);
    bus.res_valid = 1'b0;
    hs = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.blk_valid && bus.blk_ready) hs++;
      @(negedge clk);
    end
    n_checks++;
    if (hs !== 1) begin n_fail++; $display("FAIL sim_outstanding_kept: got %0d further issues required 1", hs); end

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bus.blk_ready = 1'b0; bus.res_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.res_ready) rr_seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (rr_seen !== 1'b0) begin n_fail++; $display("FAIL idle_res_ready: got 1 required 0"); end
    start_mb(13'h004);
    bus.blk_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (bus.res_valid && bus.res_ready) comps++;
      if (mb_done) begin
        pulses++;
        n_checks++;
        if (comps !== TOTAL) begin n_fail++; $display("FAIL idle_res_counted: completions %0d required %0d", comps, TOTAL); end
      end
      @(negedge clk);
      if (pulses > 0) break;
    end
    bus.res_valid = 1'b0;
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL sim_mb_done: pulses %0d required 1", pulses); end
  endtask

  task automatic test_abort();
    int issued, comps;
    logic done_seen;
    issued = 0; comps = 0; done_seen = 1'b0;
    do_reset();
    start_mb(13'h005);
    bus.blk_ready = 1'b1;
    for (int c = 0; c < 30 && issued < 10; c++) begin
      bus.res_valid = (comps < 6);
      #1;
      if (bus.blk_valid && bus.blk_ready) issued++;
      if (bus.res_valid && bus.res_ready) comps++;
      @(negedge clk);
    end
    n_checks++;
    if ({issued, comps} !== {32'd10, 32'd6}) begin
      n_fail++; $display("FAIL abort_setup: issued %0d comps %0d required 10 6", issued, comps);
    end
    abort = 1'b1; bus.blk_ready = 1'b1; bus.res_valid = 1'b1;
    #1;
    n_checks++;
    if ({bus.blk_valid, bus.res_ready} !== 2'b00) begin
      n_fail++; $display("FAIL abort_mask: valid/res_ready %b required 00", {bus.blk_valid, bus.res_ready});
    end
    if (mb_done) done_seen = 1'b1;
    @(negedge clk);
    abort = 1'b0; bus.blk_ready = 1'b0; bus.res_valid = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy %0b required 0", busy); end
    for (int c = 0; c < 3; c++) begin
      if (mb_done) done_seen = 1'b1;
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (done_seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: mb_done seen, required none"); end
    start_mb(13'h006);
    #1;
    n_checks++;
    if ({bus.blk_valid, bus.blk_comp, bus.blk_idx} !== {1'b1, 2'd0, 4'd0}) begin
      n_fail++; $display("FAIL abort_restart: valid %0b comp %0d idx %0d required 1/0/0",
                         bus.blk_valid, bus.blk_comp, bus.blk_idx);
    end
  endtask

  task automatic test_guards();
    int hs;
    hs = 0;
    do_reset();
    start_mb(13'h0C3);
    bus.blk_ready = 1'b1; bus.res_valid = 1'b1;
    for (int c = 0; c < 60 && hs < TOTAL; c++) begin
      #1;
      if (bus.blk_valid && bus.blk_ready) hs++;
      @(negedge clk);
    end
    bus.blk_ready = 1'b0; bus.res_valid = 1'b0;
    #1;
    n_checks++;
    if ({busy, bus.blk_valid, bus.res_ready} !== 3'b101) begin
      n_fail++; $display("FAIL drain_state: busy/valid/res_ready %b required 101", {busy, bus.blk_valid, bus.res_ready});
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, mb_done, bus.blk_valid, bus.res_ready, bus.blk_comp, bus.blk_idx, bus.blk_mb_addr} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%0b done=%0b bv=%0b rr=%0b comp=%0d idx=%0d addr=%0h, required all 0",
               busy, mb_done, bus.blk_valid, bus.res_ready, bus.blk_comp, bus.blk_idx, bus.blk_mb_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    start_mb(13'h111);
    #1;
    n_checks++;
    if (bus.blk_mb_addr !== 13'h111) begin n_fail++; $display("FAIL guard_latch: addr %0h required 111", bus.blk_mb_addr); end
    mb_addr = 13'h1FF; mb_start = 1'b1;
    @(negedge clk);
    mb_start = 1'b0;
    #1;
    n_checks++;
    if ({busy, bus.blk_mb_addr, bus.blk_idx} !== {1'b1, 13'h111, 4'd0}) begin
      n_fail++; $display("FAIL guard_start_ignored: busy %0b addr %0h idx %0d required 1 111 0",
                         busy, bus.blk_mb_addr, bus.blk_idx);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; mb_start = 1'b0; mb_addr = '0; abort = 1'b0;
    bus.blk_ready = 1'b0; bus.res_valid = 1'b0;
    test_reset();
    test_smoke();
    test_backpressure();
    test_stall();
    test_simultaneous();
    test_abort();
    test_guards();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
